dac_jesd204_tx_framer: RTL and testbench

Transmit-side counterpart of the ADC JESD204 deframer. Accepts parallel DAC samples through a valid/ready handshake and packs them MSB-octet-first into per-lane 32-bit JESD204 transport words. Tail bits are zero-filled. Drives the link-layer TX data bus with a registered output. Gates data with a link start-up state machine and reports underflow when the link consumes a word but no sample is available.

---
 rtl/dac_jesd204_tx_framer.sv | 152 +++++++++++++++
 tb/tb_dac_jesd204_tx_framer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_jesd204_tx_framer.sv
// JESD204 transmit framer: packs DAC samples MSB-octet-first into 32-bit lanes,
// gated by a tx_ready start-up sequence, with sticky/saturating underflow reporting.
//
// state   | meaning
// IDLE    | link not in data phase, zero fill
// WAIT    | tx_ready seen, counting START_DELAY zero words
// RUN     | samples accepted and framed while tx_ready holds
module dac_jesd204_tx_framer #(
  parameter int NUM_LANES      = 1,
  parameter int NUM_CHANNELS   = 1,
  parameter int CHANNEL_WIDTH  = 16,
  parameter int OCT_PER_SAMPLE = 2,
  parameter int START_DELAY    = 4
) (
  input  logic                                                  tx_clk,
  input  logic                                                  tx_rst,
  input  logic [NUM_LANES*CHANNEL_WIDTH*(4/OCT_PER_SAMPLE)-1:0] dac_data,
  input  logic                                                  dac_valid,
  output logic                                                  dac_ready,
  input  logic                                                  tx_ready,
  output logic [NUM_LANES*32-1:0]                               tx_data,
  output logic                                                  tx_valid,
  output logic                                                  underflow,
  output logic [15:0]                                           underflow_count,
  input  logic                                                  underflow_clr
);

  localparam int SPW = 4 / OCT_PER_SAMPLE;
  localparam int DPW = SPW * NUM_LANES / NUM_CHANNELS;
  localparam bit HD = NUM_LANES > NUM_CHANNELS;
  localparam logic [7:0] DLY = 8'(START_DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN} state_t;

  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [NUM_LANES*32-1:0] framed;
  logic accept, uf_event;

  function automatic logic [15:0] left_align(input logic [CHANNEL_WIDTH-1:0] s);
    return 16'(s) << (16 - CHANNEL_WIDTH);
  endfunction

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (tx_ready) begin
          if (START_DELAY == 0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = DLY;
          end
        end
      end
      ST_WAIT: begin
        if (!tx_ready) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!tx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dac_ready = (state == ST_RUN) & tx_ready;
  assign accept    = dac_ready & dac_valid;
  assign uf_event  = (state == ST_RUN) & tx_ready & !dac_valid;

  // Sample k = j + i*DPW; octet placement depends on octets/sample and high-density mode.
  generate
    if (OCT_PER_SAMPLE == 1) begin : g_oct1
      always_comb begin
        framed = '0;
        for (int k = 0; k < NUM_CHANNELS*DPW; k++) begin
          framed[k*8 +: 8] = 8'(dac_data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]) << (8 - CHANNEL_WIDTH);
        end
      end
    end else if (HD) begin : g_hd
      localparam int H = NUM_LANES / NUM_CHANNELS / 2;
      logic [15:0] ext;
      always_comb begin
        framed = '0;
        ext    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          for (int j = 0; j < DPW; j++) begin
            ext = left_align(dac_data[(i*DPW + j)*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
            framed[(i*H + j%H)*64 + (j/H)*8 +: 8]      = ext[15:8];
            framed[(i*H + j%H)*64 + (j/H)*8 + 32 +: 8] = ext[7:0];
          end
        end
      end
    end else begin : g_oct2
      logic [15:0] ext;
      always_comb begin
        framed = '0;
        ext    = '0;
        for (int k = 0; k < NUM_CHANNELS*DPW; k++) begin
          ext = left_align(dac_data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
          framed[k*16 +: 8]     = ext[15:8];
          framed[k*16 + 8 +: 8] = ext[7:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (accept) begin
      tx_data  <= framed;
      tx_valid <= 1'b1;
    end else begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end
  end

  // A clear coinciding with an event leaves exactly that one event recorded.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else if (underflow_clr) begin
      underflow       <= uf_event;
      underflow_count <= {15'd0, uf_event};
    end else if (uf_event) begin
      underflow <= 1'b1;
      if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_jesd204_tx_framer.sv
// Scoreboard bench for dac_jesd204_tx_framer: four parameter sets share control
// inputs; a reference model predicts readiness, framed words and underflow state.
module tb_dac_jesd204_tx_framer;

  logic tx_clk = 1'b0;
  logic tx_rst = 1'b0;
  logic tx_ready = 1'b0;
  logic dac_valid = 1'b0;
  logic underflow_clr = 1'b0;
  logic [63:0] dd [4];

  logic [255:0] td_all;
  logic [3:0]   tv_all, rdy_all, uf_all;
  logic [63:0]  ufc_all;

  always #5 tx_clk = ~tx_clk;

  function automatic int cfg_l(input int g);   return (g >= 2) ? 2 : 1; endfunction
  function automatic int cfg_c(input int g);   return (g == 3) ? 2 : 1; endfunction
  function automatic int cfg_cw(input int g);  return (g == 1) ? 14 : (g == 3) ? 6 : 16; endfunction
  function automatic int cfg_oct(input int g); return (g == 3) ? 1 : 2; endfunction
  function automatic int cfg_sd(input int g);  return (g == 2) ? 0 : (g == 3) ? 2 : 4; endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L   = cfg_l(g);
    localparam int C   = cfg_c(g);
    localparam int CW  = cfg_cw(g);
    localparam int OCT = cfg_oct(g);
    localparam int SD  = cfg_sd(g);
    localparam int DW  = L * CW * (4 / OCT);
    logic [L*32-1:0] t;
    logic [15:0] c;
    logic r, v, u;
    dac_jesd204_tx_framer #(
      .NUM_LANES(L), .NUM_CHANNELS(C), .CHANNEL_WIDTH(CW),
      .OCT_PER_SAMPLE(OCT), .START_DELAY(SD)
    ) u_dut (
      .tx_clk(tx_clk), .tx_rst(tx_rst), .dac_data(dd[g][DW-1:0]),
      .dac_valid(dac_valid), .dac_ready(r), .tx_ready(tx_ready),
      .tx_data(t), .tx_valid(v), .underflow(u), .underflow_count(c),
      .underflow_clr(underflow_clr)
    );
    assign td_all[g*64 +: 64]  = 64'(t);
    assign tv_all[g]           = v;
    assign rdy_all[g]          = r;
    assign uf_all[g]           = u;
    assign ufc_all[g*16 +: 16] = c;
  end

  typedef struct packed {
    logic        v;
    logic [63:0] d;
    logic        uf;
    logic [15:0] ufc;
  } exp_t;

  exp_t exp_q [4][$];
  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_rdy = '0;
  logic [3:0]  m_uf = '0;
  int          m_ufc [4];
  int          hi_cnt = 0;
  logic        mon_en = 1'b0, rst_chk = 1'b0, lit_td_chk = 1'b0, lit_uf_chk = 1'b0;
  logic [63:0] lit_td [3];
  logic [15:0] lit_uf_val = '0;

  // Reference framing straight from the octet placement rules, using shifts on a flat word.
  function automatic logic [63:0] frame(input logic [63:0] d, input int g);
    int l, c, cw, oct, dpw, h, k, p;
    logic [63:0] r, s, v;
    l = cfg_l(g); c = cfg_c(g); cw = cfg_cw(g); oct = cfg_oct(g);
    dpw = (4 / oct) * l / c;
    h = (l > c) ? l / c / 2 : 1;
    r = '0;
    for (int i = 0; i < c; i++) begin
      for (int j = 0; j < dpw; j++) begin
        k = i * dpw + j;
        s = (d >> (k * cw)) & ((64'd1 << cw) - 64'd1);
        if (oct == 1) begin
          r |= (s << (8 - cw)) << (k * 8);
        end else begin
          v = s << (16 - cw);
          p = (l > c) ? (i * h + j % h) * 64 + (j / h) * 8 : k * 16;
          r |= (v >> 8) << p;
          r |= (v & 64'hFF) << (p + ((l > c) ? 32 : 8));
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s dut%0d: got %h expected %h at %0t", name, g, act, exp, $time);
    end
  endtask

  always @(negedge tx_clk) begin
    exp_t e;
    if (rst_chk) begin
      for (int g = 0; g < 4; g++) begin
        chk("rst_tx_data", g, td_all[g*64 +: 64], 64'd0);
        chk("rst_tx_valid", g, 64'(tv_all[g]), 64'd0);
        chk("rst_dac_ready", g, 64'(rdy_all[g]), 64'd0);
        chk("rst_underflow", g, 64'(uf_all[g]), 64'd0);
        chk("rst_underflow_count", g, 64'(ufc_all[g*16 +: 16]), 64'd0);
        exp_q[g].delete();
      end
    end else if (mon_en) begin
      for (int g = 0; g < 4; g++) begin
        chk("dac_ready", g, 64'(rdy_all[g]), 64'(exp_rdy[g]));
        if (exp_q[g].size() != 0) begin
          e = exp_q[g].pop_front();
          chk("tx_valid", g, 64'(tv_all[g]), 64'(e.v));
          chk("tx_data", g, td_all[g*64 +: 64], e.d);
          chk("underflow", g, 64'(uf_all[g]), 64'(e.uf));
          chk("underflow_count", g, 64'(ufc_all[g*16 +: 16]), 64'(e.ufc));
        end
      end
    end
    if (lit_td_chk) begin
      for (int g = 0; g < 3; g++) chk("directed_tx_data", g, td_all[g*64 +: 64], lit_td[g]);
    end
    if (lit_uf_chk) begin
      chk("directed_underflow", 0, 64'(uf_all[0]), 64'd1);
      chk("directed_underflow_count", 0, 64'(ufc_all[15:0]), 64'(lit_uf_val));
    end
  end

  // One cycle: drive inputs, predict the next edge's outputs, queue them after the edge.
  task automatic step(input logic v, input logic r, input logic clr, input logic rnd);
    exp_t e [4];
    logic run, acc, ev;
    dac_valid = v;
    tx_ready = r;
    underflow_clr = clr;
    if (rnd) for (int g = 0; g < 4; g++) dd[g] = {$urandom, $urandom};
    for (int g = 0; g < 4; g++) begin
      run = (hi_cnt >= cfg_sd(g) + 1);
      exp_rdy[g] = run & r;
      acc = run & r & v;
      ev = run & r & !v;
      if (clr) begin
        m_uf[g] = ev;
        m_ufc[g] = ev ? 1 : 0;
      end else if (ev) begin
        m_uf[g] = 1'b1;
        if (m_ufc[g] < 65535) m_ufc[g]++;
      end
      e[g].v = acc;
      e[g].d = acc ? frame(dd[g], g) : 64'd0;
      e[g].uf = m_uf[g];
      e[g].ufc = 16'(m_ufc[g]);
    end
    if (r) begin
      if (hi_cnt < 1000) hi_cnt++;
    end else begin
      hi_cnt = 0;
    end
    @(posedge tx_clk);
    lit_td_chk = 1'b0;
    lit_uf_chk = 1'b0;
    for (int g = 0; g < 4; g++) exp_q[g].push_back(e[g]);
    #1;
  endtask

  initial begin
    for (int g = 0; g < 4; g++) begin
      dd[g] = '0;
      m_ufc[g] = 0;
    end
    for (int g = 0; g < 3; g++) lit_td[g] = '0;
    #1;
    tx_rst = 1'b1;
    rst_chk = 1'b1;
    repeat (2) @(posedge tx_clk);
    #1;
    tx_rst = 1'b0;
    rst_chk = 1'b0;
    mon_en = 1'b1;

    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Start-up with fixed samples held on dac_data.
    dd[0] = 64'h5678_1234;
    dd[1] = 64'h7FFF;
    dd[2] = 64'h3A3B_2A2B_1A1B_0A0B;
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
    lit_td[0] = 64'h7856_3412;
    lit_td[1] = 64'h0400_FCFF;
    lit_td[2] = 64'h3B2B_1B0B_3A2A_1A0A;
    lit_td_chk = 1'b1;

    // Three underflows, then clear coinciding with a fourth.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    lit_uf_val = 16'd3;
    lit_uf_chk = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    lit_uf_val = 16'd1;
    lit_uf_chk = 1'b1;

    // tx_ready drop and re-raise.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b1);

    repeat (400) step($urandom_range(0, 9) < 8, $urandom_range(0, 19) != 0,
                      $urandom_range(0, 29) == 0, 1'b1);

    // Asynchronous reset mid-RUN.
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    tx_rst = 1'b1;
    rst_chk = 1'b1;
    exp_rdy = '0;
    @(negedge tx_clk);
    @(posedge tx_clk);
    #1;
    tx_rst = 1'b0;
    rst_chk = 1'b0;
    hi_cnt = 0;
    m_uf = '0;
    for (int g = 0; g < 4; g++) m_ufc[g] = 0;
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b1);

    // Sustained underflow until the counter saturates.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (65540) step(1'b0, 1'b1, 1'b0, 1'b0);
    lit_uf_val = 16'hFFFF;
    lit_uf_chk = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    @(negedge tx_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
